// File: rtl/serial_instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_instr_loader_pkg
// Description : Shared constants for the serial instruction loader: FSM state
//               encoding, frame-mode codes, the bit-counter width helper and
//               the field-sequencing helper.
//               Optional feature macro: SERIAL_INSTR_LOADER_PARITY_EN
//               (adds the S_PAR state).
// Revision    : 1.0 - initial release
// ============================================================================
package serial_instr_loader_pkg;

  // FSM state encoding (3 bits, exported on the debug 'state' port)
  localparam logic [2:0] S_OP     = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
  localparam logic [2:0] S_PAR    = 3'd3;
`endif
  localparam logic [2:0] S_COMMIT = 3'd4;

  // Frame modes carried in opcode[1:0]
  localparam logic [1:0] MODE_NOP  = 2'b00;
  localparam logic [1:0] MODE_ADDR = 2'b01;
  localparam logic [1:0] MODE_DATA = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Counter width able to index every bit of the widest field.
  function automatic int cnt_width(input int op_w, input int addr_w, input int data_w);
    int m;
    m = op_w;
    if (addr_w > m) m = addr_w;
    if (data_w > m) m = data_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // State that follows a completed field 'cur' for a frame of the given mode.
  function automatic logic [2:0] next_field_state(input logic [2:0] cur, input logic [1:0] mode);
    logic [2:0] nxt;
    nxt = S_COMMIT;
    case (cur)
      S_OP: begin
        case (mode)
          MODE_ADDR, MODE_BOTH: nxt = S_ADDR;
          MODE_DATA:            nxt = S_DATA;
          default:              nxt = S_COMMIT;
        endcase
      end
      S_ADDR:  nxt = (mode == MODE_BOTH) ? S_DATA : S_COMMIT;
      default: nxt = S_COMMIT;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_instr_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_instr_loader_if
// Description : Bus bundle between the bit-serial sender / downstream
//               registers and the serial instruction loader.
//               slave  : loader side (takes the serial stream, drives results)
//               master : environment side
//               Signals: bit_valid, bit_in, abort (to loader);
//               opcode, addr, data, addr_load, data_load, frame_done, busy,
//               overrun, state [, parity_err] (from loader).
//               Optional feature macro: SERIAL_INSTR_LOADER_PARITY_EN
//               (adds parity_err).
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_instr_loader_if #(
  parameter int OP_W   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              bit_valid;
  logic              bit_in;
  logic              abort;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              addr_load;
  logic              data_load;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic [2:0]        state;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
  logic              parity_err;
`endif

  modport slave (
    input  bit_valid, bit_in, abort,
    output opcode, addr, data, addr_load, data_load, frame_done, busy, overrun, state
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output bit_valid, bit_in, abort,
    input  opcode, addr, data, addr_load, data_load, frame_done, busy, overrun, state
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
    , input parity_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/serial_instr_loader_field_counter.sv
`default_nettype none
// ============================================================================
// Module      : sil_field_counter
// Description : Bit counter shared by all serial fields. Counts enabled bits
//               and flags the last bit of a field whose width is supplied at
//               run time; wraps to zero on that bit.
//               Ports: clk, rst (async, active high), clr (sync clear),
//               en (count this cycle), field_w (current field width),
//               last (en && this bit is the final one of the field).
// Revision    : 1.0 - initial release
// ============================================================================
module sil_field_counter #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             en,
  input  wire logic [CNT_W:0]   field_w,
  output logic                  last
);
  localparam logic [CNT_W:0]   C_ONE_W = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = en && ({1'b0, cnt_q} == (field_w - C_ONE_W));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = last ? '0 : (cnt_q + C_ONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule
`default_nettype wire

// File: rtl/serial_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_instr_loader
// Description : Deserialises a framed bit stream (opcode, then optional
//               address and data fields, MSB first) and commits the fields
//               to registered outputs with one-cycle load strobes.
//               Ports: clk, rst (async, active high), bus (slave modport of
//               serial_instr_loader_if).
//               Optional feature macro: SERIAL_INSTR_LOADER_PARITY_EN
//               (even-parity bit after every field, parity_err pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_instr_loader
  import serial_instr_loader_pkg::*;
#(
  parameter int OP_W   = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  serial_instr_loader_if.slave  bus
);
  localparam int CNT_W = cnt_width(OP_W, ADDR_W, DATA_W);
  localparam logic [CNT_W:0] OP_LEN   = (CNT_W+1)'(OP_W);
  localparam logic [CNT_W:0] ADDR_LEN = (CNT_W+1)'(ADDR_W);
  localparam logic [CNT_W:0] DATA_LEN = (CNT_W+1)'(DATA_W);

  logic [2:0]        state_q, state_d;
  logic [OP_W-1:0]   op_sr_q, op_sr_d, opcode_q, opcode_d, op_shift;
  logic [ADDR_W-1:0] addr_sr_q, addr_sr_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_sr_q, data_sr_d, data_q, data_d;
  logic              addr_load_q, addr_load_d, data_load_q, data_load_d;
  logic              frame_done_q, frame_done_d, overrun_q, overrun_d;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
  logic              par_q, par_d, parity_err_q, parity_err_d;
  logic [2:0]        field_q, field_d;
`endif

  logic              in_field, abort_now, cnt_en, field_last;
  logic [CNT_W:0]    field_w;

  // Abort is ignored while committing so a started commit always completes.
  assign in_field  = (state_q == S_OP) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign abort_now = bus.abort && (state_q != S_COMMIT);
  assign cnt_en    = bus.bit_valid && in_field && !abort_now;
  assign op_shift  = OP_W'({op_sr_q, bus.bit_in});

  always_comb begin
    field_w = OP_LEN;
    case (state_q)
      S_ADDR:  field_w = ADDR_LEN;
      S_DATA:  field_w = DATA_LEN;
      default: field_w = OP_LEN;
    endcase
  end

  sil_field_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (abort_now),
    .en      (cnt_en),
    .field_w (field_w),
    .last    (field_last)
  );

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_OP;
    else     state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = S_OP;
    end else begin
      case (state_q)
        S_OP, S_ADDR, S_DATA: begin
          if (field_last) begin
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
            state_d = S_PAR;
`else
            // In S_OP the mode bits are only complete including this bit.
            state_d = next_field_state(state_q,
                        (state_q == S_OP) ? op_shift[1:0] : op_sr_q[1:0]);
`endif
          end
        end
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
        S_PAR: begin
          if (bus.bit_valid)
            state_d = (bus.bit_in == par_q) ? next_field_state(field_q, op_sr_q[1:0]) : S_OP;
        end
`endif
        S_COMMIT: state_d = S_OP;
        default:  state_d = S_OP;
      endcase
    end
  end

  // ---------------- datapath / output logic ----------------
  always_comb begin
    op_sr_d      = op_sr_q;
    addr_sr_d    = addr_sr_q;
    data_sr_d    = data_sr_q;
    opcode_d     = opcode_q;
    addr_d       = addr_q;
    data_d       = data_q;
    addr_load_d  = 1'b0;
    data_load_d  = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q | (bus.bit_valid && (state_q == S_COMMIT));
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
    par_d        = par_q;
    field_d      = field_q;
    parity_err_d = 1'b0;
`endif
    if (abort_now) begin
      op_sr_d   = '0;
      addr_sr_d = '0;
      data_sr_d = '0;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
      par_d     = 1'b0;
`endif
    end else begin
      case (state_q)
        S_OP:   if (bus.bit_valid) op_sr_d   = op_shift;
        S_ADDR: if (bus.bit_valid) addr_sr_d = ADDR_W'({addr_sr_q, bus.bit_in});
        S_DATA: if (bus.bit_valid) data_sr_d = DATA_W'({data_sr_q, bus.bit_in});
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
        S_PAR: begin
          if (bus.bit_valid) begin
            par_d = 1'b0;
            if (bus.bit_in != par_q) begin
              parity_err_d = 1'b1;
              op_sr_d      = '0;
              addr_sr_d    = '0;
              data_sr_d    = '0;
            end
          end
        end
`endif
        S_COMMIT: begin
          // opcode bit 0 selects an address field, bit 1 a data field
          opcode_d     = op_sr_q;
          frame_done_d = 1'b1;
          if (op_sr_q[0]) begin
            addr_d      = addr_sr_q;
            addr_load_d = 1'b1;
          end
          if (op_sr_q[1]) begin
            data_d      = data_sr_q;
            data_load_d = 1'b1;
          end
        end
        default: ;
      endcase
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
      // Running parity of the field being received; remembers which field it was.
      if (in_field && bus.bit_valid) begin
        par_d   = par_q ^ bus.bit_in;
        field_d = state_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sr_q      <= '0;
      addr_sr_q    <= '0;
      data_sr_q    <= '0;
      opcode_q     <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      addr_load_q  <= 1'b0;
      data_load_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
      par_q        <= 1'b0;
      field_q      <= S_OP;
      parity_err_q <= 1'b0;
`endif
    end else begin
      op_sr_q      <= op_sr_d;
      addr_sr_q    <= addr_sr_d;
      data_sr_q    <= data_sr_d;
      opcode_q     <= opcode_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      addr_load_q  <= addr_load_d;
      data_load_q  <= data_load_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
      par_q        <= par_d;
      field_q      <= field_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.opcode     = opcode_q;
  assign bus.addr       = addr_q;
  assign bus.data       = data_q;
  assign bus.addr_load  = addr_load_q;
  assign bus.data_load  = data_load_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == S_COMMIT);
  assign bus.overrun    = overrun_q;
  assign bus.state      = state_q;
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_serial_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_instr_loader
// Description : Self-checking bench for serial_instr_loader. Table of frames
//               with hand-computed results, plus directed sequences for
//               abort, overrun, asynchronous reset and (with
//               SERIAL_INSTR_LOADER_PARITY_EN) parity errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_instr_loader;
  localparam int OP_W = 2, ADDR_W = 8, DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_instr_loader_if #(.OP_W(OP_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  serial_instr_loader #(.OP_W(OP_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit bits_q[$];

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  addr;
    logic [15:0] data;
    int          gap;     // 0: none, 1: cycling 0..3, 2: two idles
    logic [7:0]  e_addr;
    logic [15:0] e_data;
    logic        e_al;
    logic        e_dl;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push_raw(input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  // Field bits, followed by their even-parity bit when the feature is on.
  task automatic push_field(input logic [31:0] v, input int w);
    push_raw(v, w);
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
    begin
      bit p;
      p = 1'b0;
      for (int i = 0; i < w; i++) p = p ^ v[i];
      bits_q.push_back(p);
    end
`endif
  endtask

  task automatic push_frame(input logic [1:0] mode, input logic [7:0] a, input logic [15:0] d);
    push_field({30'd0, mode}, 2);
    if (mode[0]) push_field({24'd0, a}, 8);
    if (mode[1]) push_field({16'd0, d}, 16);
  endtask

  // Called at a falling edge; returns at the falling edge after the strobe.
  task automatic strobe(input bit b);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_q(input int gap_mode);
    int g;
    for (int i = 0; i < bits_q.size(); i++) begin
      strobe(bits_q[i]);
      if (i < bits_q.size() - 1) begin
        g = (gap_mode == 1) ? (i % 4) : gap_mode;
        repeat (g) @(negedge clk);
      end
    end
    bits_q.delete();
  endtask

  // Entered in the commit cycle (one cycle after the last strobe).
  task automatic finish_check(input int id, input logic [1:0] e_op, input logic [7:0] e_addr,
                              input logic [15:0] e_data, input bit e_al, input bit e_dl,
                              input bit abort_c, input bit strobe_c);
    chk($sformatf("f%0d busy_in_commit", id), {31'd0, bus.busy}, 32'd1);
    chk($sformatf("f%0d state_commit", id), {29'd0, bus.state}, 32'd4);
    if (abort_c) bus.abort = 1'b1;
    if (strobe_c) begin
      bus.bit_in    = 1'b1;
      bus.bit_valid = 1'b1;
    end
    @(negedge clk);
    bus.abort     = 1'b0;
    bus.bit_valid = 1'b0;
    chk($sformatf("f%0d strobes", id), {29'd0, bus.addr_load, bus.data_load, bus.frame_done},
        {29'd0, e_al, e_dl, 1'b1});
    chk($sformatf("f%0d opcode", id), {30'd0, bus.opcode}, {30'd0, e_op});
    chk($sformatf("f%0d addr", id), {24'd0, bus.addr}, {24'd0, e_addr});
    chk($sformatf("f%0d data", id), {16'd0, bus.data}, {16'd0, e_data});
    chk($sformatf("f%0d state_after", id), {29'd0, bus.state, bus.busy}, 32'd0);
    @(negedge clk);
    chk($sformatf("f%0d strobes_clear", id),
        {29'd0, bus.addr_load, bus.data_load, bus.frame_done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 8'hA5, 16'h1111, 1, 8'hA5, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{2'b11, 8'h3C, 16'hBEEF, 0, 8'h3C, 16'hBEEF, 1'b1, 1'b1};
    vecs[2] = '{2'b00, 8'hFF, 16'hFFFF, 0, 8'h3C, 16'hBEEF, 1'b0, 1'b0};
    vecs[3] = '{2'b10, 8'h00, 16'h5A5A, 2, 8'h3C, 16'h5A5A, 1'b0, 1'b1};
    vecs[4] = '{2'b01, 8'h81, 16'h0000, 1, 8'h81, 16'h5A5A, 1'b1, 1'b0};
    vecs[5] = '{2'b11, 8'h00, 16'hFFFF, 0, 8'h00, 16'hFFFF, 1'b1, 1'b1};

    rst = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.abort     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {bus.opcode, bus.addr, bus.data}, 32'd0);
    chk("reset flags", {26'd0, bus.addr_load, bus.data_load, bus.frame_done, bus.busy,
                        bus.overrun, 1'b0}, 32'd0);
    chk("reset state", {29'd0, bus.state}, 32'd0);
`ifdef SERIAL_INSTR_LOADER_PARITY_EN
    chk("reset parity_err", {31'd0, bus.parity_err}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven frames ----
    for (int v = 0; v < 6; v++) begin
      push_frame(vecs[v].mode, vecs[v].addr, vecs[v].data);
      send_q(vecs[v].gap);
      finish_check(v, vecs[v].mode, vecs[v].e_addr, vecs[v].e_data,
                   vecs[v].e_al, vecs[v].e_dl, 1'b0, 1'b0);
    end

    // ---- abort together with the 9th data bit ----
    push_field(32'd2, 2);
    push_raw(32'hAB, 8);
    send_q(0);
    bus.abort = 1'b1;
    strobe(1'b1);
    bus.abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("abort no_strobe c%0d", c),
          {29'd0, bus.addr_load, bus.data_load, bus.frame_done}, 32'd0);
      @(negedge clk);
    end
    chk("abort state", {29'd0, bus.state}, 32'd0);
    chk("abort data_kept", {16'd0, bus.data}, 32'h0000FFFF);
    push_frame(2'b10, 8'h00, 16'h1234);
    send_q(0);
    finish_check(10, 2'b10, 8'h00, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);

    // ---- abort during commit is ignored ----
    push_frame(2'b11, 8'h42, 16'h0F0F);
    send_q(1);
    finish_check(11, 2'b11, 8'h42, 16'h0F0F, 1'b1, 1'b1, 1'b1, 1'b0);

    // ---- strobe during busy: dropped, overrun sticky ----
    chk("overrun before", {31'd0, bus.overrun}, 32'd0);
    push_frame(2'b01, 8'h11, 16'h0000);
    send_q(0);
    finish_check(12, 2'b01, 8'h11, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("overrun set", {31'd0, bus.overrun}, 32'd1);
    push_frame(2'b10, 8'h00, 16'hC33C);
    send_q(0);
    finish_check(13, 2'b10, 8'h11, 16'hC33C, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("overrun sticky", {31'd0, bus.overrun}, 32'd1);

    // ---- asynchronous reset mid-frame ----
    push_raw(32'h1D, 5);
    send_q(0);
    #2 rst = 1'b1;
    #1;
    chk("rst outputs", {bus.opcode, bus.addr, bus.data}, 32'd0);
    chk("rst flags", {27'd0, bus.addr_load, bus.data_load, bus.frame_done, bus.busy,
                      bus.overrun}, 32'd0);
    chk("rst state", {29'd0, bus.state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push_frame(2'b01, 8'h77, 16'h0000);
    send_q(0);
    finish_check(14, 2'b01, 8'h77, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_INSTR_LOADER_PARITY_EN
    // ---- explicit parity bits: good, then a flipped address parity ----
    push_raw(32'd1, 2); push_raw(32'd1, 1); push_raw(32'hA5, 8); push_raw(32'd0, 1);
    send_q(0);
    finish_check(15, 2'b01, 8'hA5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    push_raw(32'd1, 2); push_raw(32'd1, 1); push_raw(32'h5A, 8); push_raw(32'd1, 1);
    send_q(0);
    chk("par_err pulse", {31'd0, bus.parity_err}, 32'd1);
    chk("par_err state", {29'd0, bus.state}, 32'd0);
    chk("par_err no_load", {30'd0, bus.addr_load, bus.frame_done}, 32'd0);
    @(negedge clk);
    chk("par_err clear", {31'd0, bus.parity_err}, 32'd0);
    chk("par_err addr_kept", {24'd0, bus.addr}, 32'h000000A5);
    chk("par_err still_no_load", {30'd0, bus.addr_load, bus.frame_done}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
